// File: rtl/l0_fill_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : l0_sched_pkg
// Brief   : Shared types and constants for the L0 fill scheduler.
// Revision: 1.0
// ============================================================================
package l0_sched_pkg;

    localparam int NUM_REQ    = 3;
    localparam int REQ_WEIGHT = 0;
    localparam int REQ_INPUT  = 1;
    localparam int REQ_OUTPUT = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARB      = 3'd1,
        OVERHEAD = 3'd2,
        BURST    = 3'd3,
        DRAIN    = 3'd4
    } sched_state_t;

    // Next requester index in round-robin order, wrapping 2 -> 0.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'(REQ_OUTPUT)) ? 2'(REQ_WEIGHT) : idx + 2'd1;
    endfunction

    function automatic logic [NUM_REQ-1:0] req_onehot(input logic [1:0] idx);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/l0_fill_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : l0_fill_scheduler_if
// Brief   : Request/grant and Mem/L0 enable bundle of the L0 fill scheduler.
// Revision: 1.0
// ============================================================================
interface l0_fill_scheduler_if
    import l0_sched_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 4,
    parameter int L0_ADDR_WIDTH  = 3,
    parameter int LEN_WIDTH      = 4
);
    logic [NUM_REQ-1:0]                Req;
    logic [NUM_REQ*MEM_ADDR_WIDTH-1:0] Req_Base;
    logic [NUM_REQ*LEN_WIDTH-1:0]      Req_Len;
    logic [NUM_REQ-1:0]                Grant;
    logic [NUM_REQ-1:0]                Done;
    logic                              Mem_En_R;
    logic [MEM_ADDR_WIDTH-1:0]         Mem_Addr_Read;
    logic [NUM_REQ-1:0]                L0_En_W;
    logic [L0_ADDR_WIDTH-1:0]          L0_Addr_Write;
    logic                              Busy;

    // Requesters / loading logic side.
    modport master (
        output Req, Req_Base, Req_Len,
        input  Grant, Done, Mem_En_R, Mem_Addr_Read, L0_En_W, L0_Addr_Write, Busy
    );

    // Scheduler side.
    modport slave (
        input  Req, Req_Base, Req_Len,
        output Grant, Done, Mem_En_R, Mem_Addr_Read, L0_En_W, L0_Addr_Write, Busy
    );
endinterface
`default_nettype wire

// File: rtl/l0_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : l0_rr_arbiter
// Brief   : 3-way round-robin pick with pointer register; L0_FIXED_PRIORITY_EN
//           selects fixed priority weight > input > output instead.
// Revision: 1.0
// ============================================================================
module l0_rr_arbiter
    import l0_sched_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_update,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [1:0]         o_idx,
    output logic               o_any
);

    logic [1:0] r_ptr;
    logic [1:0] w_idx;
    logic       w_any;
    logic       w_ptr_load;

    assign w_any = |i_req;

`ifdef L0_FIXED_PRIORITY_EN
    always_comb begin
        w_idx = 2'(REQ_WEIGHT);
        if (i_req[REQ_WEIGHT])
            w_idx = 2'(REQ_WEIGHT);
        else if (i_req[REQ_INPUT])
            w_idx = 2'(REQ_INPUT);
        else if (i_req[REQ_OUTPUT])
            w_idx = 2'(REQ_OUTPUT);
    end

    // Pointer is kept frozen at its reset value in this build.
    assign w_ptr_load = 1'b0;
`else
    logic [1:0] w_c1;
    logic [1:0] w_c2;
    logic [1:0] w_c3;

    assign w_c1 = rr_next(r_ptr);
    assign w_c2 = rr_next(w_c1);
    assign w_c3 = rr_next(w_c2);

    always_comb begin
        w_idx = w_c1;
        if (i_req[w_c1])
            w_idx = w_c1;
        else if (i_req[w_c2])
            w_idx = w_c2;
        else if (i_req[w_c3])
            w_idx = w_c3;
    end

    assign w_ptr_load = i_update & w_any;
`endif

    // Reset pointer at the output requester so the weight requester wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ptr <= 2'(REQ_OUTPUT);
        else if (w_ptr_load)
            r_ptr <= w_idx;
    end

    assign o_idx   = w_idx;
    assign o_any   = w_any;
    assign o_grant = w_any ? req_onehot(w_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/l0_fill_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : l0_fill_scheduler
// Brief   : Arbitrates weight/input/output L0 fills onto the shared Mem read
//           port. Config macro: L0_FIXED_PRIORITY_EN (fixed priority arbiter).
// Revision: 1.0
// ============================================================================
module l0_fill_scheduler
    import l0_sched_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 4,
    parameter int L0_ADDR_WIDTH  = 3,
    parameter int LEN_WIDTH      = 4,
    parameter int START_OVERHEAD = 100,
    parameter int OVERHEAD_WIDTH = 7
)(
    input  logic                clk,
    input  logic                Reset,
    l0_fill_scheduler_if.slave  bus
);

    localparam logic [OVERHEAD_WIDTH-1:0] c_ovh_load = OVERHEAD_WIDTH'(START_OVERHEAD);

    sched_state_t               r_state;
    logic [NUM_REQ-1:0]         r_grant;
    logic [NUM_REQ-1:0]         r_done;
    logic [MEM_ADDR_WIDTH-1:0]  r_base;
    logic [LEN_WIDTH-1:0]       r_len;
    logic [LEN_WIDTH-1:0]       r_offset;
    logic [OVERHEAD_WIDTH-1:0]  r_ovh_cnt;
    logic                       r_mem_en;
    logic [MEM_ADDR_WIDTH-1:0]  r_mem_addr;
    logic                       r_busy;
    logic [NUM_REQ-1:0]         r_l0_en;
    logic [L0_ADDR_WIDTH-1:0]   r_l0_addr;

    logic [NUM_REQ-1:0]         w_arb_grant;
    logic [1:0]                 w_arb_idx;
    logic                       w_arb_any;
    logic                       w_arb_update;
    logic [MEM_ADDR_WIDTH-1:0]  w_sel_base;
    logic [LEN_WIDTH-1:0]       w_sel_len;
    logic [LEN_WIDTH-1:0]       w_next_off;
    logic [MEM_ADDR_WIDTH-1:0]  w_next_addr;
    logic                       w_last;

    assign w_arb_update = (r_state == ARB);

    l0_rr_arbiter u_arb (
        .clk      (clk),
        .rst      (Reset),
        .i_req    (bus.Req),
        .i_update (w_arb_update),
        .o_grant  (w_arb_grant),
        .o_idx    (w_arb_idx),
        .o_any    (w_arb_any)
    );

    assign w_sel_base  = bus.Req_Base[w_arb_idx*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
    assign w_sel_len   = bus.Req_Len[w_arb_idx*LEN_WIDTH +: LEN_WIDTH];
    assign w_next_off  = r_offset + 1'b1;
    assign w_next_addr = r_base + MEM_ADDR_WIDTH'(w_next_off);
    assign w_last      = (r_offset == r_len - 1'b1);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_done     <= '0;
            r_base     <= '0;
            r_len      <= '0;
            r_offset   <= '0;
            r_ovh_cnt  <= '0;
            r_mem_en   <= 1'b0;
            r_mem_addr <= '0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|bus.Req) begin
                        r_state <= ARB;
                        r_busy  <= 1'b1;
                    end
                end

                ARB: begin
                    if (!w_arb_any) begin
                        // Request withdrawn before it could be served.
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_grant <= w_arb_grant;
                        r_base  <= w_sel_base;
                        r_len   <= w_sel_len;
                        if (w_sel_len == '0) begin
                            r_state <= DRAIN;
                            r_done  <= w_arb_grant;
                        end else if (START_OVERHEAD == 0) begin
                            r_state    <= BURST;
                            r_mem_en   <= 1'b1;
                            r_mem_addr <= w_sel_base;
                            r_offset   <= '0;
                        end else begin
                            r_state   <= OVERHEAD;
                            r_ovh_cnt <= c_ovh_load;
                        end
                    end
                end

                OVERHEAD: begin
                    r_ovh_cnt <= r_ovh_cnt - 1'b1;
                    if (r_ovh_cnt <= OVERHEAD_WIDTH'(1)) begin
                        r_state    <= BURST;
                        r_mem_en   <= 1'b1;
                        r_mem_addr <= r_base;
                        r_offset   <= '0;
                    end
                end

                BURST: begin
                    if (w_last) begin
                        r_state  <= DRAIN;
                        r_mem_en <= 1'b0;
                        r_done   <= r_grant;
                    end else begin
                        r_offset   <= w_next_off;
                        r_mem_addr <= w_next_addr;
                    end
                end

                DRAIN: begin
                    r_state <= IDLE;
                    r_done  <= '0;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state  <= IDLE;
                    r_grant  <= '0;
                    r_done   <= '0;
                    r_mem_en <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    // Mem read data returns one cycle later, so the L0 write side trails the read.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_l0_en   <= '0;
            r_l0_addr <= '0;
        end else begin
            r_l0_en   <= r_mem_en ? r_grant : '0;
            r_l0_addr <= L0_ADDR_WIDTH'(r_offset);
        end
    end

    assign bus.Grant         = r_grant;
    assign bus.Done          = r_done;
    assign bus.Mem_En_R      = r_mem_en;
    assign bus.Mem_Addr_Read = r_mem_addr;
    assign bus.L0_En_W       = r_l0_en;
    assign bus.L0_Addr_Write = r_l0_addr;
    assign bus.Busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_l0_fill_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_l0_fill_scheduler
// Brief   : Scoreboard bench for l0_fill_scheduler (START_OVERHEAD = 3).
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_l0_fill_scheduler;
    import l0_sched_pkg::*;

    localparam int MEM_ADDR_WIDTH = 4;
    localparam int L0_ADDR_WIDTH  = 3;
    localparam int LEN_WIDTH      = 4;
    localparam int START_OVERHEAD = 3;
    localparam int OVERHEAD_WIDTH = 7;

    logic clk   = 1'b0;
    logic Reset = 1'b1;

    always #5 clk = ~clk;

    l0_fill_scheduler_if #(
        .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH),
        .L0_ADDR_WIDTH  (L0_ADDR_WIDTH),
        .LEN_WIDTH      (LEN_WIDTH)
    ) bus ();

    l0_fill_scheduler #(
        .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH),
        .L0_ADDR_WIDTH  (L0_ADDR_WIDTH),
        .LEN_WIDTH      (LEN_WIDTH),
        .START_OVERHEAD (START_OVERHEAD),
        .OVERHEAD_WIDTH (OVERHEAD_WIDTH)
    ) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int n_cmp    = 0;
    int n_err    = 0;
    int done_cnt = 0;
    int rd_seen  = 0;
    int quota [3];
    int exp_rd   [$];
    int exp_wr   [$];
    int exp_done [$];

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected traffic of one burst: reads, trailing L0 writes {en,addr}, one Done.
    task automatic push_burst(input int idx, input int base, input int len);
        for (int k = 0; k < len; k++) begin
            exp_rd.push_back((base + k) % (1 << MEM_ADDR_WIDTH));
            exp_wr.push_back(((1 << idx) << L0_ADDR_WIDTH) | (k % (1 << L0_ADDR_WIDTH)));
        end
        exp_done.push_back(1 << idx);
    endtask

    task automatic monitor();
        int e;
        if (Reset) return;
        if (bus.Mem_En_R) begin
            rd_seen++;
            check("grant_onehot", int'($onehot(bus.Grant)), 1);
            if (exp_rd.size() == 0)
                check("unexpected_read", int'(bus.Mem_Addr_Read), -1);
            else begin
                e = exp_rd.pop_front();
                check("read_addr", int'(bus.Mem_Addr_Read), e);
            end
        end
        if (bus.L0_En_W != '0) begin
            if (exp_wr.size() == 0)
                check("unexpected_l0_write", int'({bus.L0_En_W, bus.L0_Addr_Write}), -1);
            else begin
                e = exp_wr.pop_front();
                check("l0_write", int'({bus.L0_En_W, bus.L0_Addr_Write}), e);
            end
        end
        if (bus.Done != '0) begin
            done_cnt++;
            if (exp_done.size() == 0)
                check("unexpected_done", int'(bus.Done), -1);
            else begin
                e = exp_done.pop_front();
                check("done", int'(bus.Done), e);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.Done[i] && quota[i] > 0) begin
                    quota[i]--;
                    if (quota[i] == 0) bus.Req[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
    endtask

    task automatic wait_dones(input int target, input int budget);
        int t;
        t = 0;
        while (done_cnt < target && t < budget) begin
            tick();
            t++;
        end
        check("done_count", done_cnt, target);
        t = 0;
        while (bus.Busy && t < 8) begin
            tick();
            t++;
        end
        check("idle_after_bursts", int'(bus.Busy), 0);
    endtask

    task automatic do_reset();
        bus.Req = '0;
        Reset   = 1'b1;
        repeat (2) @(negedge clk);
        Reset    = 1'b0;
        done_cnt = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, int'(bus.Grant), 0);
        check({tag, "_done"},  int'(bus.Done), 0);
        check({tag, "_mem_en"}, int'(bus.Mem_En_R), 0);
        check({tag, "_mem_addr"}, int'(bus.Mem_Addr_Read), 0);
        check({tag, "_l0_en"}, int'(bus.L0_En_W), 0);
        check({tag, "_busy"}, int'(bus.Busy), 0);
    endtask

    initial begin
        int t;
        int rd0;
        int order [6];

        bus.Req      = '0;
        bus.Req_Base = '0;
        bus.Req_Len  = '0;
        for (int i = 0; i < NUM_REQ; i++) quota[i] = 0;

        // Reset state
        @(negedge clk);
        check_all_zero("reset");
        Reset = 1'b0;

        // Single weight fill: base 4, len 3
        bus.Req_Base[0 +: MEM_ADDR_WIDTH] = 4'd4;
        bus.Req_Len[0 +: LEN_WIDTH]       = 4'd3;
        quota[0] = 1;
        push_burst(0, 4, 3);
        bus.Req = 3'b001;
        t = 0;
        rd0 = rd_seen;
        while (rd_seen == rd0 && t < 20) begin
            tick();
            t++;
        end
        check("first_read_latency", t, 5);
        tick();
        check("l0_write_trails_read", int'(bus.L0_En_W), 1);
        wait_dones(1, 30);
        check("grant_released", int'(bus.Grant), 0);

        // All three requesting, len 2 each
        do_reset();
        bus.Req_Base = {4'd12, 4'd10, 4'd8};
        bus.Req_Len  = {4'd2, 4'd2, 4'd2};
`ifdef L0_FIXED_PRIORITY_EN
        order = '{0, 0, 0, 0, 1, 2};
        quota[0] = 4; quota[1] = 1; quota[2] = 1;
`else
        order = '{0, 1, 2, 0, 1, 2};
        quota[0] = 2; quota[1] = 2; quota[2] = 2;
`endif
        for (int b = 0; b < 6; b++) push_burst(order[b], 8 + 2 * order[b], 2);
        bus.Req = 3'b111;
        wait_dones(6, 200);

        // Zero-length fill for input requester
        do_reset();
        bus.Req_Len[LEN_WIDTH +: LEN_WIDTH] = 4'd0;
        quota[1] = 1;
        push_burst(1, 0, 0);
        rd0 = rd_seen;
        bus.Req = 3'b010;
        t = 0;
        while (done_cnt == 0 && t < 10) begin
            tick();
            t++;
        end
        check("zero_len_done_latency", t, 2);
        check("zero_len_no_read", rd_seen, rd0);
        wait_dones(1, 10);

        // Mem address wrap: base 14, len 4
        do_reset();
        bus.Req_Base[0 +: MEM_ADDR_WIDTH] = 4'd14;
        bus.Req_Len[0 +: LEN_WIDTH]       = 4'd4;
        quota[0] = 1;
        push_burst(0, 14, 4);
        bus.Req = 3'b001;
        wait_dones(1, 40);

        // L0 address wrap: output requester, base 3, len 10
        do_reset();
        bus.Req_Base[2*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH] = 4'd3;
        bus.Req_Len[2*LEN_WIDTH +: LEN_WIDTH]            = 4'd10;
        quota[2] = 1;
        push_burst(2, 3, 10);
        bus.Req = 3'b100;
        wait_dones(1, 40);

        // Reset during the second burst cycle
        do_reset();
        bus.Req_Base[0 +: MEM_ADDR_WIDTH] = 4'd4;
        bus.Req_Len[0 +: LEN_WIDTH]       = 4'd5;
        quota[0] = 1;
        push_burst(0, 4, 5);
        bus.Req = 3'b001;
        t = 0;
        rd0 = rd_seen;
        while (rd_seen == rd0 && t < 20) begin
            tick();
            t++;
        end
        check("reset_test_burst_start", t, 5);
        @(posedge clk);
        #1;
        Reset = 1'b1;
        #1;
        check_all_zero("mid_burst_reset");
        exp_rd.delete();
        exp_wr.delete();
        exp_done.delete();
        bus.Req = '0;
        for (int i = 0; i < NUM_REQ; i++) quota[i] = 0;
        @(negedge clk);
        Reset    = 1'b0;
        done_cnt = 0;
        repeat (6) tick();
        check("no_done_after_reset", done_cnt, 0);
        check("idle_after_reset", int'(bus.Busy), 0);

        // Pointer back at reset value: weight wins over input
        bus.Req_Base[0 +: MEM_ADDR_WIDTH]              = 4'd1;
        bus.Req_Len[0 +: LEN_WIDTH]                    = 4'd1;
        bus.Req_Base[MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH] = 4'd6;
        bus.Req_Len[LEN_WIDTH +: LEN_WIDTH]            = 4'd1;
        quota[0] = 1;
        quota[1] = 1;
        push_burst(0, 1, 1);
        push_burst(1, 6, 1);
        bus.Req = 3'b011;
        wait_dones(2, 60);

        check("leftover_reads", exp_rd.size(), 0);
        check("leftover_writes", exp_wr.size(), 0);
        check("leftover_dones", exp_done.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/l0_fill_scheduler.md
Name: l0_fill_scheduler

Overview:
Schedules L0 buffer fills from the shared Mem SRAM read port. Three requesters compete for one Mem read port: index 0 = weight, 1 = input, 2 = output. Each fill is a contiguous burst from a Mem base address into its L0 buffer starting at L0 address 0. The block sits between the L0 status/loading logic and the Mem/L0 enable and address muxes, and replaces free-running loading counters with explicit grant/done handshakes.

Parameters:
Mem_Addr_Width, 4, Mem read address width (widest of weight/input/output SRAMs)
L0_Addr_Width, 3, L0 write address width
Len_Width, 4, burst length field width; max burst 2^Len_Width-1
Start_Overhead, 100, idle cycles charged before each burst (Mem access start cost)
Overhead_Width, 7, width of the overhead counter; must hold Start_Overhead

Ports:
clk  in  1  clock
Reset  in  1  asynchronous, active-high reset
Req  in  3  per-requester fill request level; held until matching Done
Req_Base  in  3*Mem_Addr_Width  packed Mem base addresses; requester i at [i*Mem_Addr_Width +: Mem_Addr_Width]
Req_Len  in  3*Len_Width  packed burst lengths in words
Grant  out  3  one-hot; active requester, held from ARB to end of DRAIN
Done  out  3  one-cycle pulse per requester when its fill has completed
Mem_En_R  out  1  Mem read enable
Mem_Addr_Read  out  Mem_Addr_Width  Mem read address
L0_En_W  out  3  per-buffer L0 write enable
L0_Addr_Write  out  L0_Addr_Width  L0 write address
Busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values (asynchronous, immediate): state=IDLE; all outputs 0; round-robin pointer=2, so requester 0 wins first.
- Decided interface: one clock, clk; reset is asynchronous and active-high, named Reset.
- States: IDLE, ARB, OVERHEAD, BURST, DRAIN.
- IDLE: if any Req is high, go to ARB next cycle.
- ARB (1 cycle):
  - Pick the first requester with Req high, searching from pointer+1 modulo 3.
  - Latch its base and length, assert its Grant bit, update pointer to the winner.
  - If the latched length is 0: go to DRAIN with no Mem access.
  - Otherwise: load overhead counter with Start_Overhead and go to OVERHEAD.
- OVERHEAD:
  - Decrement the counter each cycle; no memory activity.
  - When counter==1 (or Start_Overhead==0), go to BURST next cycle.
  - Start_Overhead=0 skips this state entirely.
- BURST:
  - Each cycle: Mem_En_R=1, Mem_Addr_Read = base + offset, with offset 0..len-1.
  - Address add wraps modulo 2^Mem_Addr_Width.
  - After issuing offset len-1, go to DRAIN.
- Read latency is 1 cycle:
  - L0_En_W[g] and L0_Addr_Write = offset[L0_Addr_Width-1:0] are registered copies of the previous cycle's Mem_En_R and offset.
  - Last L0 write therefore lands in the first DRAIN cycle.
  - L0 offsets wrap modulo 2^L0_Addr_Width if len exceeds L0 depth (caller's responsibility; no error).
- DRAIN (1 cycle):
  - Pulse Done[g] in this cycle; Grant drops next cycle.
  - Return to IDLE; re-arbitration starts no earlier than the cycle after DRAIN.
- Deasserting Req mid-burst has no effect: the granted burst completes and Done still pulses.
- Requester re-asserting Req in the same cycle as its Done is treated as a new request.
- Simultaneous requests are resolved only by the pointer. No starvation: each pending requester is served within 2 other bursts.
- Reset mid-burst: outputs clear immediately, in-flight data is discarded, and no Done is issued.

Optional Feature:
L0_FIXED_PRIORITY_EN
- Defined: fixed priority weight > input > output; pointer is unused and stays at reset value.
- Undefined: round-robin as specified above.

Decomposition:
- Shared package l0_sched_pkg holds:
  - state enum (IDLE=0, ARB=1, OVERHEAD=2, BURST=3, DRAIN=4);
  - requester index constants REQ_WEIGHT=0, REQ_INPUT=1, REQ_OUTPUT=2;
  - NUM_REQ=3.
- One natural sub-module: l0_rr_arbiter (combinational pick plus pointer register, 3 requesters), which also contains the L0_FIXED_PRIORITY_EN variant.

Test Plan:
- Start_Overhead=3; Req=001, base0=4, len0=3 -> Mem_En_R for 3 cycles with addr 4,5,6, starting 5 cycles after Req rises; L0_En_W=001 with addr 0,1,2 one cycle later; Done=001 pulse in DRAIN.
- Req=111 held, all len=2 -> grant order 0,1,2,0; Grant always one-hot; each Done pulses exactly once per burst.
- Same stimulus with L0_FIXED_PRIORITY_EN -> grant order 0,0,... while Req[0] is held; 1 is served only after Req[0] drops.
- len1=0 -> ARB then DRAIN, Done[1] pulses 2 cycles after leaving IDLE, Mem_En_R stays 0.
- base=14, len=4, Mem_Addr_Width=4 -> read addresses 14,15,0,1.
- Assert Reset during second BURST cycle -> all outputs 0 in the same cycle, state IDLE, no Done; next Req=010 is granted after pointer reset.
